// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// Shared widths and enums for the instruction/data memory arbiter.
package Types;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CMD_I  = 3'd1,
      CMD_DR = 3'd2,
      CMD_DW = 3'd3,
      RESP_I = 3'd4,
      RESP_D = 3'd5
   } arb_state_t;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_t;
endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// Avalon-MM read-only and read/write bus bundles with host/agent views.
interface AvalonMmRead;
   import Types::*;
   logic [ADDR_W-1:0] address;
   logic              read;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;
   logic              waitrequest;

   modport Host  (output address, read, input  readdata, readdatavalid, waitrequest);
   modport Agent (input  address, read, output readdata, readdatavalid, waitrequest);
endinterface

interface AvalonMmRw;
   import Types::*;
   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [BE_W-1:0]   byteenable;
   logic [DATA_W-1:0] writedata;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;
   logic              waitrequest;

   modport Host  (output address, read, write, byteenable, writedata,
                  input  readdata, readdatavalid, waitrequest);
   modport Agent (input  address, read, write, byteenable, writedata,
                  output readdata, readdatavalid, waitrequest);
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// Round-robin arbiter sharing one Avalon-MM memory port between the CPU
// instruction-fetch and load/store ports, one transaction in flight at a time.
module mem_arbiter
   import Types::*;
(
   input  wire logic  clk,
   input  wire logic  rst,
   AvalonMmRead.Agent ibus,
   AvalonMmRw.Agent   dbus,
   AvalonMmRw.Host    mem
);

   arb_state_t        state_q, state_d;
   grant_t            last_q, last_d;
   logic              mask_i_q, mask_i_d;
   logic              mask_d_q, mask_d_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BE_W-1:0]   be_q, be_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic req_i, req_d, accept, pick_d;

   assign req_i  = ibus.read & ~mask_i_q;
   assign req_d  = (dbus.read | dbus.write) & ~mask_d_q;
   assign accept = ~mem.waitrequest;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         last_q   <= GRANT_I;
         mask_i_q <= 1'b0;
         mask_d_q <= 1'b0;
         addr_q   <= '0;
         be_q     <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         mask_i_q <= mask_i_d;
         mask_d_q <= mask_d_d;
         addr_q   <= addr_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
      end
   end

   // Masks live for one cycle only; they are set on completion and cleared otherwise.
   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      mask_i_d = 1'b0;
      mask_d_d = 1'b0;
      addr_d   = addr_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      pick_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_i || req_d) begin
               pick_d = req_d & (~req_i | (last_q == GRANT_I));
               if (pick_d) begin
                  last_d  = GRANT_D;
                  addr_d  = dbus.address;
                  be_d    = dbus.byteenable;
                  wdata_d = dbus.writedata;
                  state_d = dbus.write ? CMD_DW : CMD_DR;
               end else begin
                  last_d  = GRANT_I;
                  addr_d  = ibus.address;
                  be_d    = '1;
                  wdata_d = '0;
                  state_d = CMD_I;
               end
            end
         end
         CMD_I:  if (accept) state_d = RESP_I;
         CMD_DR: if (accept) state_d = RESP_D;
         CMD_DW: begin
            if (accept) begin
               state_d  = IDLE;
               mask_d_d = 1'b1;
            end
         end
         RESP_I: begin
            if (mem.readdatavalid) begin
               state_d  = IDLE;
               mask_i_d = 1'b1;
            end
         end
         RESP_D: begin
            if (mem.readdatavalid) begin
               state_d  = IDLE;
               mask_d_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem.read       = (state_q == CMD_I) || (state_q == CMD_DR);
   assign mem.write      = (state_q == CMD_DW);
   assign mem.address    = addr_q;
   assign mem.byteenable = be_q;
   assign mem.writedata  = wdata_q;

   // Responses reach only the port that owns the in-flight transaction.
   assign ibus.waitrequest   = ~((state_q == CMD_I) && accept);
   assign dbus.waitrequest   = ~(((state_q == CMD_DR) || (state_q == CMD_DW)) && accept);
   assign ibus.readdatavalid = (state_q == RESP_I) && mem.readdatavalid;
   assign dbus.readdatavalid = (state_q == RESP_D) && mem.readdatavalid;
   assign ibus.readdata      = (state_q == RESP_I) ? mem.readdata : '0;
   assign dbus.readdata      = (state_q == RESP_D) ? mem.readdata : '0;

endmodule
`default_nettype wire
